// File: rtl/adler32_wide_if.sv
// rtl/adler32_wide_if.sv - message framing, data beat and checksum result bundle for adler32_wide
interface adler32_wide_if #(
    parameter int BYTES_PER_BEAT = 4,
    parameter int SIZE_WIDTH     = 32
);
    logic                        size_valid;
    logic [SIZE_WIDTH-1:0]       size;
    logic                        data_start;
    logic                        data_valid;
    logic [8*BYTES_PER_BEAT-1:0] data;
    logic                        busy;
    logic                        checksum_valid;
    logic [31:0]                 checksum;
    logic                        size_err;

    modport master (
        output size_valid, size, data_start, data_valid, data,
        input  busy, checksum_valid, checksum, size_err
    );

    modport slave (
        input  size_valid, size, data_start, data_valid, data,
        output busy, checksum_valid, checksum, size_err
    );
endinterface

// File: rtl/adler32_wide.sv
// rtl/adler32_wide.sv - Adler-32 engine consuming BYTES_PER_BEAT bytes per beat
// A and B are kept fully reduced mod 65521 after every beat.
module adler32_wide #(
    parameter int BYTES_PER_BEAT = 4,
    parameter int SIZE_WIDTH     = 32
) (
    input  logic           clock,
    input  logic           rst_n,
    adler32_wide_if.slave  bus
);
    localparam int          KW  = $clog2(BYTES_PER_BEAT + 1);
    localparam logic [16:0] MOD = 17'd65521;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [15:0]           a_q, a_d, b_q, b_d;
    logic [SIZE_WIDTH-1:0] rem_q, rem_d;
    logic [31:0]           checksum_q, checksum_d;
    logic                  checksum_valid_q, checksum_valid_d;
    logic                  size_err_q, size_err_d;
    logic                  busy_q, busy_d;

    logic [KW-1:0]         k;
    logic [11:0]           sum_d;
    logic [13:0]           wsum;
    logic [15:0]           a_new, b_new;
    logic                  consume;
    logic                  last_beat;

    // 2^16 == 15 (mod 65521): one fold brings x below 2*65521, one subtract finishes
    function automatic logic [15:0] mod_fold(input logic [23:0] x);
        logic [16:0] f;
        f = 17'(x[15:0]) + 17'(x[23:16]) * 17'd15;
        if (f >= MOD) begin
            f = f - MOD;
        end
        return f[15:0];
    endfunction

    always_comb begin
        k     = '0;
        sum_d = '0;
        wsum  = '0;
        if (rem_q >= SIZE_WIDTH'(BYTES_PER_BEAT)) begin
            k = KW'(BYTES_PER_BEAT);
        end else begin
            k = KW'(rem_q);
        end
        for (int i = 0; i < BYTES_PER_BEAT; i++) begin
            if (i < int'(k)) begin
                sum_d = sum_d + 12'(bus.data[8*i +: 8]);
                wsum  = wsum + 14'((int'(k) - i) * int'(bus.data[8*i +: 8]));
            end
        end
        a_new     = mod_fold(24'(a_q) + 24'(sum_d));
        b_new     = mod_fold(24'(b_q) + 24'(k) * 24'(a_q) + 24'(wsum));
        last_beat = (rem_q <= SIZE_WIDTH'(BYTES_PER_BEAT));
    end

    always_comb begin
        state_d          = state_q;
        a_d              = a_q;
        b_d              = b_q;
        rem_d            = rem_q;
        checksum_d       = checksum_q;
        checksum_valid_d = 1'b0;
        size_err_d       = 1'b0;
        consume          = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.size_valid) begin
                    a_d = 16'd1;
                    b_d = 16'd0;
                    if (bus.size == '0) begin
                        state_d          = S_DONE;
                        checksum_valid_d = 1'b1;
                        checksum_d       = 32'h0000_0001;
                    end else begin
                        state_d = S_WAIT;
                        rem_d   = bus.size;
                    end
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                consume    = bus.data_valid & bus.data_start;
                size_err_d = bus.size_valid;
            end
            S_RUN: begin
                consume    = bus.data_valid;
                size_err_d = bus.size_valid;
            end
            default: state_d = S_IDLE;
        endcase

        if (consume) begin
            a_d   = a_new;
            b_d   = b_new;
            rem_d = rem_q - SIZE_WIDTH'(k);
            if (last_beat) begin
                state_d          = S_DONE;
                checksum_valid_d = 1'b1;
                checksum_d       = {b_new, a_new};
            end else begin
                state_d = S_RUN;
            end
        end

        busy_d = (state_d == S_WAIT) || (state_d == S_RUN);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            a_q              <= 16'd1;
            b_q              <= 16'd0;
            rem_q            <= '0;
            checksum_q       <= 32'h0000_0001;
            checksum_valid_q <= 1'b0;
            size_err_q       <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            a_q              <= a_d;
            b_q              <= b_d;
            rem_q            <= rem_d;
            checksum_q       <= checksum_d;
            checksum_valid_q <= checksum_valid_d;
            size_err_q       <= size_err_d;
            busy_q           <= busy_d;
        end
    end

    assign bus.busy           = busy_q;
    assign bus.checksum_valid = checksum_valid_q;
    assign bus.checksum       = checksum_q;
    assign bus.size_err       = size_err_q;
endmodule

// File: tb/tb_adler32_wide.sv
// tb/tb_adler32_wide.sv - scoreboard bench for adler32_wide at 4 lanes plus 1/3/8-lane long runs
module tb_adler32_wide;
    localparam int BPB = 4;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    logic rst_w_n = 1'b0;
    always #5 clock = ~clock;

    adler32_wide_if #(.BYTES_PER_BEAT(BPB), .SIZE_WIDTH(32)) bus ();
    adler32_wide #(.BYTES_PER_BEAT(BPB), .SIZE_WIDTH(32)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int wide_done = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] sum;
        int          due;
    } exp_t;
    exp_t sb[$];
    int   err_due[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] adler_ref(input byte unsigned m[$]);
        int unsigned a = 1;
        int unsigned b = 0;
        foreach (m[i]) begin
            a = (a + m[i]) % 65521;
            b = (b + a) % 65521;
        end
        return {b[15:0], a[15:0]};
    endfunction

    always @(negedge clock) begin : mon
        exp_t e;
        int   d;
        if (rst_n) begin
            if (bus.checksum_valid) begin
                if (sb.size() == 0) begin
                    check_eq("valid_without_expect", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check_eq("checksum", bus.checksum, e.sum);
                    check_eq("latency", 32'(cyc), 32'(e.due));
                end
            end
            if (bus.size_err) begin
                if (err_due.size() == 0) begin
                    check_eq("size_err_without_expect", 32'(err_due.size()), 32'd1);
                end else begin
                    d = err_due.pop_front();
                    check_eq("size_err_latency", 32'(cyc), 32'(d));
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        bus.size_valid = 1'b0;
        bus.data_valid = 1'b0;
        bus.data_start = 1'b0;
        bus.data       = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // stop_after >= 0 drives only that many beats; err_beat injects a size_valid on that beat
    task automatic send_msg(input byte unsigned m[$], input int max_gap, input int stop_after,
                            input int err_beat, input logic [31:0] exp);
        int n;
        int nb;
        n  = m.size();
        nb = (n + BPB - 1) / BPB;
        step();
        bus.size_valid = 1'b1;
        bus.size       = 32'(n);
        if (n == 0) begin
            sb.push_back('{exp, cyc + 1});
            return;
        end
        for (int b = 0; b < nb; b++) begin
            if (stop_after >= 0 && b == stop_after) return;
            repeat ($urandom_range(0, max_gap)) step();
            step();
            for (int i = 0; i < BPB; i++) begin
                if (b * BPB + i < n) bus.data[8*i +: 8] = m[b * BPB + i];
            end
            bus.data_valid = 1'b1;
            bus.data_start = (b == 0) ? 1'b1 : ((max_gap > 0) ? 1'($urandom_range(0, 1)) : 1'b0);
            if (b == err_beat) begin
                bus.size_valid = 1'b1;
                bus.size       = 32'd7;
                err_due.push_back(cyc + 1);
            end
            if (b == nb - 1 && stop_after < 0) sb.push_back('{exp, cyc + 1});
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_wide
        localparam int W = (g == 0) ? 1 : ((g == 1) ? 3 : 8);
        localparam int N = (g == 0) ? 20000 : 100000;
        adler32_wide_if #(.BYTES_PER_BEAT(W), .SIZE_WIDTH(32)) wbus ();
        adler32_wide #(.BYTES_PER_BEAT(W), .SIZE_WIDTH(32)) wdut (
            .clock (clock),
            .rst_n (rst_w_n),
            .bus   (wbus)
        );
        initial begin
            byte unsigned ff[$];
            logic [31:0]  exp;
            bit           seen;
            int           lat;
            for (int i = 0; i < N; i++) ff.push_back(8'hFF);
            exp = adler_ref(ff);
            wbus.size_valid = 1'b0;
            wbus.size       = '0;
            wbus.data_start = 1'b0;
            wbus.data_valid = 1'b0;
            wbus.data       = '0;
            wait (rst_w_n);
            @(posedge clock); #1;
            wbus.size_valid = 1'b1;
            wbus.size       = 32'(N);
            @(posedge clock); #1;
            wbus.size_valid = 1'b0;
            for (int b = 0; b < (N + W - 1) / W; b++) begin
                wbus.data_valid = 1'b1;
                wbus.data_start = (b == 0);
                wbus.data       = '1;
                @(posedge clock); #1;
            end
            wbus.data_valid = 1'b0;
            seen = 1'b0;
            lat  = 0;
            for (int t = 0; t < 4 && !seen; t++) begin
                @(negedge clock);
                if (wbus.checksum_valid) begin
                    seen = 1'b1;
                    lat  = t;
                end
            end
            check_eq($sformatf("t5_w%0d_valid", W), 32'(seen), 32'd1);
            check_eq($sformatf("t5_w%0d_latency", W), 32'(lat), 32'd0);
            check_eq($sformatf("t5_w%0d_checksum", W), wbus.checksum, exp);
            wide_done++;
        end
    end

    initial begin
        byte unsigned abc[$];
        byte unsigned wiki[$];
        byte unsigned empty[$];
        byte unsigned one_ff[$];
        byte unsigned big[$];
        abc    = '{8'h61, 8'h62, 8'h63};
        wiki   = '{8'h57, 8'h69, 8'h6b, 8'h69, 8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
        one_ff = '{8'hFF};
        for (int i = 0; i < 100000; i++) big.push_back(8'hFF);

        bus.size_valid = 1'b0;
        bus.size       = '0;
        bus.data_start = 1'b0;
        bus.data_valid = 1'b0;
        bus.data       = '0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("reset_busy", 32'(bus.busy), 32'd0);
        check_eq("reset_valid", 32'(bus.checksum_valid), 32'd0);
        check_eq("reset_size_err", 32'(bus.size_err), 32'd0);
        check_eq("reset_checksum", bus.checksum, 32'h0000_0001);
        rst_n   = 1'b1;
        rst_w_n = 1'b1;

        send_msg(abc, 0, -1, -1, 32'h024D_0127);
        idle(3);
        send_msg(wiki, 0, -1, -1, 32'h11E6_0398);
        idle(3);
        for (int r = 0; r < 3; r++) begin
            send_msg(wiki, 3, -1, -1, 32'h11E6_0398);
            idle(2);
        end
        send_msg(empty, 0, -1, -1, 32'h0000_0001);
        idle(3);
        send_msg(one_ff, 0, -1, -1, 32'h0100_0100);
        idle(3);

        send_msg(abc, 0, -1, -1, 32'h024D_0127);
        send_msg(wiki, 0, -1, 1, 32'h11E6_0398);
        send_msg(empty, 0, -1, -1, 32'h0000_0001);
        send_msg(abc, 1, -1, -1, 32'h024D_0127);
        idle(3);

        step();
        bus.data_valid = 1'b1;
        bus.data_start = 1'b1;
        idle(3);

        send_msg(wiki, 0, 2, -1, 32'h0);
        step();
        check_eq("t6_busy_mid", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #2;
        check_eq("t6_busy", 32'(bus.busy), 32'd0);
        check_eq("t6_valid", 32'(bus.checksum_valid), 32'd0);
        check_eq("t6_size_err", 32'(bus.size_err), 32'd0);
        check_eq("t6_checksum", bus.checksum, 32'h0000_0001);
        step();
        rst_n = 1'b1;
        idle(2);
        send_msg(abc, 0, -1, -1, 32'h024D_0127);
        idle(3);

        send_msg(big, 0, -1, -1, adler_ref(big));
        idle(5);
        check_eq("sb_drain", 32'(sb.size()), 32'd0);
        check_eq("size_err_drain", 32'(err_due.size()), 32'd0);

        for (int i = 0; i < 50000 && wide_done < 3; i++) @(posedge clock);
        check_eq("wide_done", 32'(wide_done), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
